// File: rtl/tube_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tube_scroll_ctrl
//  Purpose  : Scrolls four tube pairs left, recycles them with LFSR gaps and
//             counts tubes passing the bird column.
//  Revision : 1.0  initial release
// ============================================================================
module tube_scroll_ctrl #(
    parameter int         SCREEN_W  = 640,
    parameter int         SCREEN_H  = 480,
    parameter int         TUBE_W    = 52,
    parameter int         GAP_H     = 120,
    parameter int         GAP_MIN   = 40,
    parameter int         SPACING   = 160,
    parameter int         SPEED     = 2,
    parameter int         BIRD_X    = 160,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       collide,
    output logic [1:0] state,
    output logic [9:0] tube_h_0,
    output logic [9:0] tube_h_1,
    output logic [9:0] tube_h_2,
    output logic [9:0] tube_h_3,
    output logic [9:0] tube_v_0,
    output logic [9:0] tube_v_1,
    output logic [9:0] tube_v_2,
    output logic [9:0] tube_v_3,
    output logic [9:0] tube_height_0,
    output logic [9:0] tube_height_1,
    output logic [9:0] tube_height_2,
    output logic [9:0] tube_height_3,
    output logic [9:0] tube_width_0,
    output logic [9:0] tube_width_1,
    output logic [9:0] tube_width_2,
    output logic [9:0] tube_width_3,
    output logic [9:0] tube_h_0_U,
    output logic [9:0] tube_h_1_U,
    output logic [9:0] tube_h_2_U,
    output logic [9:0] tube_h_3_U,
    output logic [9:0] tube_v_0_U,
    output logic [9:0] tube_v_1_U,
    output logic [9:0] tube_v_2_U,
    output logic [9:0] tube_v_3_U,
    output logic [9:0] tube_height_0_U,
    output logic [9:0] tube_height_1_U,
    output logic [9:0] tube_height_2_U,
    output logic [9:0] tube_height_3_U,
    output logic [9:0] tube_width_0_U,
    output logic [9:0] tube_width_1_U,
    output logic [9:0] tube_width_2_U,
    output logic [9:0] tube_width_3_U,
    output logic       pass_pulse,
    output logic [9:0] score
);

    localparam logic [10:0] c_screen_w  = 11'(SCREEN_W);
    localparam logic [10:0] c_tube_w    = 11'(TUBE_W);
    localparam logic [10:0] c_speed     = 11'(SPEED);
    localparam logic [10:0] c_bird_x    = 11'(BIRD_X);
    localparam logic [10:0] c_wrap_add  = 11'(4 * SPACING - SPEED);
    localparam logic [9:0]  c_screen_h  = 10'(SCREEN_H);
    localparam logic [9:0]  c_gap_h     = 10'(GAP_H);
    localparam logic [9:0]  c_gap_min   = 10'(GAP_MIN);
    localparam logic [9:0]  c_gap_rst   = 10'd180;
    localparam logic [9:0]  c_score_max = 10'd999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    state_t           r_state;
    logic [3:0][10:0] r_p;
    logic [3:0][9:0]  r_gap;
    logic [7:0]       r_lfsr;
    logic             r_pass;
    logic [9:0]       r_score;

    logic [3:0][10:0] w_p_next;
    logic [3:0]       w_wrap;
    logic [3:0]       w_cross;
    logic [3:0][9:0]  w_h;
    logic [3:0][9:0]  w_w;
    logic [3:0][9:0]  w_v_lo;
    logic [3:0][9:0]  w_ht_lo;
    logic             w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_tube
            logic [10:0] w_left;
            logic [10:0] w_room;

            // p is left edge + TUBE_W, so a tube partly off the left edge keeps p as its width
            assign w_wrap[i]   = (r_p[i] <= c_speed);
            assign w_p_next[i] = w_wrap[i] ? (r_p[i] + c_wrap_add) : (r_p[i] - c_speed);
            assign w_cross[i]  = (r_p[i] > c_bird_x) && (w_p_next[i] <= c_bird_x);
            assign w_left      = r_p[i] - c_tube_w;
            assign w_room      = c_screen_w - w_left;

            always_comb begin
                w_h[i] = 10'd0;
                w_w[i] = 10'd0;
                if (r_p[i] < c_tube_w) begin
                    w_h[i] = 10'd0;
                    w_w[i] = 10'(r_p[i]);
                end else if (w_left >= c_screen_w) begin
                    w_h[i] = 10'(c_screen_w);
                    w_w[i] = 10'd0;
                end else begin
                    w_h[i] = 10'(w_left);
                    w_w[i] = (w_room < c_tube_w) ? 10'(w_room) : 10'(c_tube_w);
                end
            end

            assign w_v_lo[i]  = r_gap[i] + c_gap_h;
            assign w_ht_lo[i] = c_screen_h - w_v_lo[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_pass  <= 1'b0;
            r_score <= 10'd0;
            for (int i = 0; i < 4; i++) begin
                r_p[i]   <= 11'(SCREEN_W + TUBE_W + i * SPACING);
                r_gap[i] <= c_gap_rst;
            end
        end else begin
            // free-running so the moment of start decides the gap sequence
            r_lfsr <= {r_lfsr[6:0], w_fb};
            r_pass <= 1'b0;
            case (r_state)
                ST_IDLE, ST_STOP: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_score <= 10'd0;
                        for (int i = 0; i < 4; i++) begin
                            r_p[i] <= 11'(SCREEN_W + TUBE_W + i * SPACING);
                        end
                    end
                end
                ST_RUN: begin
                    if (collide) begin
                        r_state <= ST_STOP;
                    end
                    for (int i = 0; i < 4; i++) begin
                        r_p[i] <= w_p_next[i];
                        if (w_wrap[i]) begin
                            r_gap[i] <= c_gap_min + 10'(r_lfsr);
                        end
                    end
                    if (|w_cross) begin
                        r_pass <= 1'b1;
                        if (r_score != c_score_max) begin
                            r_score <= r_score + 10'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign pass_pulse = r_pass;
    assign score      = r_score;

    assign tube_h_0 = w_h[0];
    assign tube_h_1 = w_h[1];
    assign tube_h_2 = w_h[2];
    assign tube_h_3 = w_h[3];
    assign tube_width_0 = w_w[0];
    assign tube_width_1 = w_w[1];
    assign tube_width_2 = w_w[2];
    assign tube_width_3 = w_w[3];
    assign tube_v_0 = w_v_lo[0];
    assign tube_v_1 = w_v_lo[1];
    assign tube_v_2 = w_v_lo[2];
    assign tube_v_3 = w_v_lo[3];
    assign tube_height_0 = w_ht_lo[0];
    assign tube_height_1 = w_ht_lo[1];
    assign tube_height_2 = w_ht_lo[2];
    assign tube_height_3 = w_ht_lo[3];

    assign tube_h_0_U = w_h[0];
    assign tube_h_1_U = w_h[1];
    assign tube_h_2_U = w_h[2];
    assign tube_h_3_U = w_h[3];
    assign tube_width_0_U = w_w[0];
    assign tube_width_1_U = w_w[1];
    assign tube_width_2_U = w_w[2];
    assign tube_width_3_U = w_w[3];
    assign tube_v_0_U = 10'd0;
    assign tube_v_1_U = 10'd0;
    assign tube_v_2_U = 10'd0;
    assign tube_v_3_U = 10'd0;
    assign tube_height_0_U = r_gap[0];
    assign tube_height_1_U = r_gap[1];
    assign tube_height_2_U = r_gap[2];
    assign tube_height_3_U = r_gap[3];

endmodule
`default_nettype wire

// File: tb/tb_tube_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tube_scroll_ctrl
//  Purpose  : Directed self-checking bench for tube_scroll_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tube_scroll_ctrl;

    logic       clk = 1'b0;
    logic       r_rst = 1'b0;
    logic       r_start = 1'b0;
    logic       r_collide = 1'b0;
    logic [1:0] w_state;
    logic [9:0] w_h0, w_h1, w_h2, w_h3;
    logic [9:0] w_v0, w_v1, w_v2, w_v3;
    logic [9:0] w_ht0, w_ht1, w_ht2, w_ht3;
    logic [9:0] w_w0, w_w1, w_w2, w_w3;
    logic [9:0] w_h0u, w_h1u, w_h2u, w_h3u;
    logic [9:0] w_v0u, w_v1u, w_v2u, w_v3u;
    logic [9:0] w_ht0u, w_ht1u, w_ht2u, w_ht3u;
    logic [9:0] w_w0u, w_w1u, w_w2u, w_w3u;
    logic       w_pass;
    logic [9:0] w_score;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] r_model_lfsr;
    logic [9:0] r_gap_exp;

    always #5 clk = ~clk;

    // reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5, steps every clock
    always @(posedge clk or negedge r_rst) begin
        if (!r_rst) r_model_lfsr <= 8'hA5;
        else        r_model_lfsr <= {r_model_lfsr[6:0],
                                     r_model_lfsr[7] ^ r_model_lfsr[5] ^ r_model_lfsr[4] ^ r_model_lfsr[3]};
    end

    tube_scroll_ctrl dut (
        .clk(clk), .rst(r_rst), .start(r_start), .collide(r_collide), .state(w_state),
        .tube_h_0(w_h0), .tube_h_1(w_h1), .tube_h_2(w_h2), .tube_h_3(w_h3),
        .tube_v_0(w_v0), .tube_v_1(w_v1), .tube_v_2(w_v2), .tube_v_3(w_v3),
        .tube_height_0(w_ht0), .tube_height_1(w_ht1), .tube_height_2(w_ht2), .tube_height_3(w_ht3),
        .tube_width_0(w_w0), .tube_width_1(w_w1), .tube_width_2(w_w2), .tube_width_3(w_w3),
        .tube_h_0_U(w_h0u), .tube_h_1_U(w_h1u), .tube_h_2_U(w_h2u), .tube_h_3_U(w_h3u),
        .tube_v_0_U(w_v0u), .tube_v_1_U(w_v1u), .tube_v_2_U(w_v2u), .tube_v_3_U(w_v3u),
        .tube_height_0_U(w_ht0u), .tube_height_1_U(w_ht1u),
        .tube_height_2_U(w_ht2u), .tube_height_3_U(w_ht3u),
        .tube_width_0_U(w_w0u), .tube_width_1_U(w_w1u), .tube_width_2_U(w_w2u), .tube_width_3_U(w_w3u),
        .pass_pulse(w_pass), .score(w_score)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset held 10 cycles
        tick(10);
        check_eq("rst_state", 32'(w_state), 0);
        check_eq("rst_h0", 32'(w_h0), 640);
        check_eq("rst_w0", 32'(w_w0), 0);
        check_eq("rst_v0", 32'(w_v0), 300);
        check_eq("rst_ht0", 32'(w_ht0), 180);
        check_eq("rst_ht0u", 32'(w_ht0u), 180);
        check_eq("rst_v0u", 32'(w_v0u), 0);
        check_eq("rst_h3", 32'(w_h3), 640);
        check_eq("rst_score", 32'(w_score), 0);
        check_eq("rst_pass", 32'(w_pass), 0);
        r_rst = 1'b1;
        tick(3);

        // collide ignored in IDLE
        r_collide = 1'b1;
        tick(1);
        r_collide = 1'b0;
        check_eq("idle_collide_state", 32'(w_state), 0);

        // start: enters RUN with reloaded positions (RUN cycle count n = 0)
        r_start = 1'b1;
        tick(1);
        r_start = 1'b0;
        check_eq("run_state", 32'(w_state), 1);
        check_eq("run0_h0", 32'(w_h0), 640);
        check_eq("run0_w0", 32'(w_w0), 0);
        tick(1);
        check_eq("run1_h0", 32'(w_h0), 638);
        check_eq("run1_w0", 32'(w_w0), 2);
        tick(25);
        check_eq("run26_h0", 32'(w_h0), 588);
        check_eq("run26_w0", 32'(w_w0), 52);
        check_eq("run26_h1", 32'(w_h1), 640);
        check_eq("run26_w1u", 32'(w_w1u), 0);

        // tube 0 crosses bird column at n = 266 (p0 = 160)
        tick(239);
        check_eq("n265_pass", 32'(w_pass), 0);
        check_eq("n265_score", 32'(w_score), 0);
        tick(1);
        check_eq("n266_pass", 32'(w_pass), 1);
        check_eq("n266_score", 32'(w_score), 1);
        check_eq("n266_h0", 32'(w_h0), 108);
        tick(1);
        check_eq("n267_pass", 32'(w_pass), 0);
        check_eq("n267_score", 32'(w_score), 1);

        // left clip: p0 = 30 at n = 331, p0 = 2 at n = 345
        tick(64);
        check_eq("clip30_h0", 32'(w_h0), 0);
        check_eq("clip30_w0", 32'(w_w0), 30);
        tick(14);
        check_eq("clip2_h0", 32'(w_h0), 0);
        check_eq("clip2_w0", 32'(w_w0), 2);
        check_eq("clip2_w0u", 32'(w_w0u), 2);
        r_gap_exp = 10'd40 + 10'(r_model_lfsr);

        // n = 346: tube 0 recycles to p0 = 640, tube 1 crosses bird column
        tick(1);
        check_eq("wrap_h0", 32'(w_h0), 588);
        check_eq("wrap_w0", 32'(w_w0), 52);
        check_eq("wrap_gap_u", 32'(w_ht0u), 32'(r_gap_exp));
        check_eq("wrap_v0", 32'(w_v0), 32'(r_gap_exp + 10'd120));
        check_eq("wrap_ht0", 32'(w_ht0), 32'(10'd360 - r_gap_exp));
        check_eq("wrap_h3", 32'(w_h3), 428);
        check_eq("wrap_w3", 32'(w_w3), 52);
        check_eq("t1_pass", 32'(w_pass), 1);
        check_eq("t1_score", 32'(w_score), 2);
        tick(1);
        check_eq("n347_h0", 32'(w_h0), 586);

        // collide: last RUN step still applies, then frozen
        r_collide = 1'b1;
        tick(1);
        r_collide = 1'b0;
        check_eq("stop_state", 32'(w_state), 2);
        check_eq("stop_h0", 32'(w_h0), 584);
        tick(50);
        check_eq("frz_state", 32'(w_state), 2);
        check_eq("frz_h0", 32'(w_h0), 584);
        check_eq("frz_h1", 32'(w_h1), 104);
        check_eq("frz_score", 32'(w_score), 2);
        check_eq("frz_pass", 32'(w_pass), 0);
        check_eq("frz_gap_u", 32'(w_ht0u), 32'(r_gap_exp));

        // start and collide together in STOP: restart wins
        r_start   = 1'b1;
        r_collide = 1'b1;
        tick(1);
        r_start   = 1'b0;
        r_collide = 1'b0;
        check_eq("restart_state", 32'(w_state), 1);
        check_eq("restart_h0", 32'(w_h0), 640);
        check_eq("restart_h1", 32'(w_h1), 640);
        check_eq("restart_score", 32'(w_score), 0);
        check_eq("restart_gap_kept", 32'(w_ht0u), 32'(r_gap_exp));
        tick(3);
        check_eq("rerun3_h0", 32'(w_h0), 634);
        check_eq("rerun3_w0", 32'(w_w0), 6);

        // asynchronous reset between edges
        #2;
        r_rst = 1'b0;
        #1;
        check_eq("arst_state", 32'(w_state), 0);
        check_eq("arst_h0", 32'(w_h0), 640);
        check_eq("arst_w0", 32'(w_w0), 0);
        check_eq("arst_ht0u", 32'(w_ht0u), 180);
        check_eq("arst_v0", 32'(w_v0), 300);
        check_eq("arst_score", 32'(w_score), 0);
        tick(2);
        r_rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tube_scroll_ctrl.md
Name: tube_scroll_ctrl

Overview:
Game-side tube generator that sits directly upstream of the tube pixel-address generators. It holds four tube pairs (lower and upper) and scrolls them left by SPEED pixels per clock while in RUN. Each tube is recycled off the left edge back to the right with a new pseudo-random gap. It drives the screen-space h/v/height/width bundles consumed by the address stage, and emits a pass pulse and score whenever a tube clears the bird column.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
TUBE_W, 52, tube width in pixels
GAP_H, 120, vertical opening between upper and lower tube
GAP_MIN, 40, minimum gap_top
SPACING, 160, horizontal pitch between consecutive tubes
SPEED, 2, pixels moved per RUN cycle
BIRD_X, 160, bird column used for pass detection
LFSR_SEED, 8'hA5, LFSR reset value (non-zero)

Ports:
clk  in  1  game clock (100 Hz game tick domain)
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle start/restart request
collide  in  1  one-cycle collision indication
state  out  2  00 IDLE, 01 RUN, 10 STOP
tube_h_0..3  out  10 each  lower tube left x, clamped
tube_v_0..3  out  10 each  lower tube top y
tube_height_0..3  out  10 each  lower tube height
tube_width_0..3  out  10 each  lower tube visible width
tube_h_0_U..3_U  out  10 each  upper tube left x (equals the lower tube value)
tube_v_0_U..3_U  out  10 each  upper tube top y (always 0)
tube_height_0_U..3_U  out  10 each  upper tube height
tube_width_0_U..3_U  out  10 each  upper tube width (equals the lower tube value)
pass_pulse  out  1  one cycle per tube crossing BIRD_X
score  out  10  passed-tube count, saturates at 999

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Per-tube state: p_i is 11-bit and equals left edge + TUBE_W, so it is never negative while visible. gap_i is 10-bit.
- Reset values:
  - state = IDLE; score = 0; pass_pulse = 0; lfsr = LFSR_SEED.
  - p_i = SCREEN_W + TUBE_W + i*SPACING, giving 692, 852, 1012, 1172.
  - gap_i = 180.
- Derived outputs are combinational from registers:
  - left = p_i - TUBE_W when p_i >= TUBE_W.
  - If p_i < TUBE_W: h = 0 and width = p_i (left clip).
  - Else if left >= SCREEN_W: h = SCREEN_W and width = 0.
  - Else: h = left and width = min(TUBE_W, SCREEN_W - left).
  - Lower tube: v = gap_i + GAP_H, height = SCREEN_H - v.
  - Upper tube: v = 0, height = gap_i.
- Resulting reset outputs: h = 640, width = 0, lower v = 300, lower height = 180, upper height = 180.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle in all states, so start timing seeds randomness.
- FSM transitions:
  - IDLE -> RUN on start.
  - RUN -> STOP on collide.
  - STOP -> RUN on start.
  - collide is ignored outside RUN. In RUN, start is ignored.
- Entering RUN from IDLE or STOP:
  - p_i is reloaded to its reset value; gap_i is retained.
  - score is cleared in the same cycle.
- RUN step, applied to every tube each cycle:
  - If p_i <= SPEED: p_i <= p_i - SPEED + 4*SPACING (wrap), and gap_i <= GAP_MIN + lfsr. Gap range is 40..295, so lower height is at least 65.
  - Else: p_i <= p_i - SPEED.
  - Multiple tubes recycling in the same cycle all take the same lfsr value.
- Pass detection:
  - pass_pulse = 1 in the cycle after any p_i moves from > BIRD_X to <= BIRD_X.
  - score increments by 1 in that same cycle; it holds at 999.
  - Two tubes crossing in the same step count once (impossible at the default spacing).
- IDLE and STOP: p_i, gap_i and score are frozen; pass_pulse = 0.
- Reset mid-RUN immediately restores all reset values.

Test Plan:
- Reset, hold 10 cycles -> state 00; tube_h_0 = 640, tube_width_0 = 0, tube_v_0 = 300, tube_height_0 = 180, tube_height_0_U = 180, score 0.
- start pulse, then 1 RUN cycle -> tube_h_0 = 638, tube_width_0 = 2. After 26 RUN cycles -> tube_h_0 = 588, width 52.
- Run 266 cycles -> pass_pulse high for exactly one cycle, score = 1. Tube 1 passes 80 cycles later -> score = 2.
- Run to p_0 = 30 -> tube_h_0 = 0, tube_width_0 = 30. At p_0 = 2, next cycle -> p_0 = 640, gap_0 = 40 + lfsr, tube_3 left edge 428 (pitch 160 preserved).
- collide in RUN -> STOP and all outputs frozen for 50 cycles. Assert start and collide in the same STOP cycle -> RUN, positions reloaded, score 0.
- Drive collide in IDLE -> no state change. Pulse rst low mid-RUN, asynchronously, between clock edges -> outputs at reset values before the next edge.
